// File: rtl/oser_tx.sv
// Parallel-to-serial transmitter: double-buffered word intake over valid/ready, one bit per enabled edge on Q.
// Define OSER_PARITY_EN to append an even-parity bit to every frame (frame length DATA_WIDTH+1).
module oser_tx #(
  parameter int DATA_WIDTH    = 8,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit IS_C_INVERTED = 1'b0,
  parameter bit INIT          = 1'b0
) (
  input  logic                  C,
  input  logic                  CLR_N,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  D_VALID,
  output logic                  D_READY,
  output logic                  Q,
  output logic                  Q_FRAME,
  output logic                  Q_LAST
);

`ifdef OSER_PARITY_EN
  localparam int N = DATA_WIDTH + 1;
`else
  localparam int N = DATA_WIDTH;
`endif
  localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [N-1:0]          shreg, shreg_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic                  hold_full, hold_full_n;
  logic                  q_n, q_frame_n, q_last_n;
  logic                  accept;
  logic                  clk_act;

  // Frame bit N-1 is always the first bit on the wire; parity (if any) sits at bit 0.
  function automatic logic [N-1:0] build_frame(input logic [DATA_WIDTH-1:0] word);
    logic [DATA_WIDTH-1:0] ordered;
    for (int i = 0; i < DATA_WIDTH; i++)
      ordered[i] = MSB_FIRST ? word[i] : word[DATA_WIDTH-1-i];
`ifdef OSER_PARITY_EN
    return {ordered, ^word};
`else
    return ordered;
`endif
  endfunction

  assign clk_act = C ^ IS_C_INVERTED;
  assign D_READY = ~hold_full;
  assign accept  = D_VALID & ~hold_full & CE;

  // State register: control and outputs reset, data registers do not.
  always_ff @(posedge clk_act or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      Q         <= INIT;
      Q_FRAME   <= 1'b0;
      Q_LAST    <= 1'b0;
    end else if (CE) begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
      Q         <= q_n;
      Q_FRAME   <= q_frame_n;
      Q_LAST    <= q_last_n;
    end
  end

  always_ff @(posedge clk_act) begin
    if (CE) begin
      shreg <= shreg_n;
      hold  <= hold_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          cnt_n   = '0;
          shreg_n = build_frame(D);
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_n   = cnt + 1'b1;
          shreg_n = {shreg[N-2:0], 1'b0};
          if (accept) begin
            hold_n      = D;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          cnt_n       = '0;
          shreg_n     = build_frame(hold);
          hold_full_n = accept;
          if (accept)
            hold_n = D;
        end else if (accept) begin
          // Nothing held: the new word goes straight to the shifter with no idle bit.
          cnt_n   = '0;
          shreg_n = build_frame(D);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: registered outputs follow the next state
  always_comb begin
    q_n       = INIT;
    q_frame_n = 1'b0;
    q_last_n  = 1'b0;
    if (state_n == SHIFT) begin
      q_n       = shreg_n[N-1];
      q_frame_n = 1'b1;
      q_last_n  = (cnt_n == LAST);
    end
  end

endmodule

// File: tb/tb_oser_tx.sv
// Directed bench for oser_tx: default instance (MSB first, posedge) and an LSB-first negedge instance.
module tb_oser_tx;
`ifdef OSER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       c = 1'b0;
  logic       clr_n, ce, ce2;
  logic [7:0] d, d2;
  logic       d_valid, d_valid2;
  logic       d_ready, q, q_frame, q_last;
  logic       d_ready2, q2, q_frame2, q_last2;

  int checks = 0;
  int fails  = 0;

  logic [7:0] words [3];
  logic       pars  [3];
  logic [7:0] w;
  logic       e;
  logic       erdy;

  oser_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IS_C_INVERTED(1'b0), .INIT(1'b0)) dut (
    .C(c), .CLR_N(clr_n), .CE(ce), .D(d), .D_VALID(d_valid),
    .D_READY(d_ready), .Q(q), .Q_FRAME(q_frame), .Q_LAST(q_last)
  );

  oser_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b1), .INIT(1'b0)) dut_inv (
    .C(c), .CLR_N(clr_n), .CE(ce2), .D(d2), .D_VALID(d_valid2),
    .D_READY(d_ready2), .Q(q2), .Q_FRAME(q_frame2), .Q_LAST(q_last2)
  );

  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] word, input int b, input logic par);
    return (b < 8) ? word[7-b] : par;
  endfunction

  task automatic check_bit(input string tag, input logic [7:0] word, input logic par, input int b);
    check({tag, "_q"},     32'(q),       32'(exp_bit(word, b, par)));
    check({tag, "_frame"}, 32'(q_frame), 32'd1);
    check({tag, "_last"},  32'(q_last),  32'(b == NB - 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_q"},     32'(q),       32'd0);
    check({tag, "_idle_frame"}, 32'(q_frame), 32'd0);
    check({tag, "_idle_last"},  32'(q_last),  32'd0);
  endtask

  task automatic send(input logic [7:0] word);
    d       = word;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] word, input logic par, input int start);
    for (int b = start; b < NB; b++) begin
      check_bit(tag, word, par, b);
      tick();
    end
    check_idle(tag);
  endtask

  initial begin
    clr_n = 1'b0; ce = 1'b1; ce2 = 1'b1;
    d = '0; d_valid = 1'b0; d2 = '0; d_valid2 = 1'b0;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h81;
    pars[0]  = 1'b0;  pars[1]  = 1'b0;  pars[2]  = 1'b0;

    repeat (2) tick();
    check("rst_q",     32'(q),       32'd0);
    check("rst_frame", 32'(q_frame), 32'd0);
    check("rst_last",  32'(q_last),  32'd0);
    check("rst_ready", 32'(d_ready), 32'd1);
    check("rst_q2",    32'(q2),      32'd0);
    clr_n = 1'b1;

    // Reset mid-frame after three bits of A5
    send(8'hA5);
    tick();
    tick();
    check("mid_q",     32'(q),       32'd1);
    check("mid_frame", 32'(q_frame), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("arst_q",     32'(q),       32'd0);
    check("arst_frame", 32'(q_frame), 32'd0);
    check("arst_last",  32'(q_last),  32'd0);
    check("arst_ready", 32'(d_ready), 32'd1);
    tick();
    tick();
    clr_n = 1'b1;
    repeat (3) begin
      tick();
      check_idle("post_rst");
    end

    // Single word A5 -> 1,0,1,0,0,1,0,1
    send(8'hA5);
    run_frame("a5", 8'hA5, 1'b0, 0);

    // Back-to-back FF, 00, 81 with D_VALID held high
    d = 8'hFF; d_valid = 1'b1;
    tick();
    check_bit("b2b0", 8'hFF, 1'b0, 0);
    check("b2b_rdy0", 32'(d_ready), 32'd1);
    d = 8'h00;
    tick();
    for (int pos = 1; pos < 3 * NB; pos++) begin
      w    = words[pos / NB];
      e    = exp_bit(w, pos % NB, pars[pos / NB]);
      erdy = (pos == NB) || (pos >= 2 * NB);
      check("b2b_q",     32'(q),       32'(e));
      check("b2b_frame", 32'(q_frame), 32'd1);
      check("b2b_last",  32'(q_last),  32'((pos % NB) == NB - 1));
      check("b2b_ready", 32'(d_ready), 32'(erdy));
      if (pos == 1) d = 8'h81;
      if (pos == NB + 1) d_valid = 1'b0;
      tick();
    end
    check_idle("b2b");

    // CE low for 5 cycles in the middle of 3C; a pending word must not be taken
    send(8'h3C);
    for (int b = 0; b < 3; b++) begin
      check_bit("ce_pre", 8'h3C, 1'b0, b);
      tick();
    end
    ce = 1'b0; d = 8'hFF; d_valid = 1'b1;
    repeat (5) begin
      tick();
      check_bit("ce_frz", 8'h3C, 1'b0, 3);
      check("ce_frz_ready", 32'(d_ready), 32'd1);
    end
    ce = 1'b1; d_valid = 1'b0;
    run_frame("ce_post", 8'h3C, 1'b0, 3);
    repeat (2) begin
      tick();
      check_idle("ce_none");
    end

    // LSB first on the negedge instance: 01 -> 1 then zeros
    @(negedge c); #1;
    d2 = 8'h01; d_valid2 = 1'b1;
    @(negedge c); #1;
    d_valid2 = 1'b0;
    for (int b = 0; b < NB; b++) begin
      e = (b == 0) ? 1'b1 : ((b < 8) ? 1'b0 : 1'b1);
      check("inv_q",     32'(q2),       32'(e));
      check("inv_frame", 32'(q_frame2), 32'd1);
      check("inv_last",  32'(q_last2),  32'(b == NB - 1));
      @(posedge c); #1;
      check("inv_hold_q", 32'(q2), 32'(e));
      @(negedge c); #1;
    end
    check("inv_idle_q",     32'(q2),       32'd0);
    check("inv_idle_frame", 32'(q_frame2), 32'd0);

`ifdef OSER_PARITY_EN
    send(8'h07);
    run_frame("par07", 8'h07, 1'b1, 0);
    send(8'h03);
    run_frame("par03", 8'h03, 1'b0, 0);
`else
    send(8'h96);
    run_frame("w96", 8'h96, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
